pvci2apb: RTL



---
 rtl/pvci2apb.sv | 111 +++++++++++
 1 files changed

// File: rtl/pvci2apb.sv
// pvci2apb: PVCI target to APB master bridge.
// Each single 8-bit PVCI register access becomes one 32-bit APB transfer
// (IDLE -> SETUP -> ACCESS [wait states] -> RESP), and a one-cycle
// pvci_ack pulse reports completion back to the initiator.
// Optional build macro PVCI2APB_TIMEOUT_EN adds an ACCESS wait-state
// counter. When it reaches TIMEOUT_CYCLES, the transfer is aborted with
// pvci_rerror=1.
module pvci2apb #(
  parameter logic [31:0] APB_BASE       = 32'h0000_0000,
  parameter int unsigned ADDR_SHIFT     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        pvci_valid,
  input  logic        pvci_rd,
  input  logic [7:0]  pvci_addr,
  input  logic [7:0]  pvci_wd,
  output logic        pvci_ack,
  output logic [7:0]  pvci_rdata,
  output logic        pvci_rerror,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic        psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0] state;

`ifdef PVCI2APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // APB handshake and PVCI ack are decoded straight from the state register,
  // so an asynchronous reset drops them in the same instant as the state.
  always_comb begin
    psel     = (state == SETUP) || (state == ACCESS);
    penable  = (state == ACCESS);
    pvci_ack = (state == RESP);
  end

  // Transfer sequencer: captures the request in IDLE, runs the APB phases,
  // and registers read data and error status on completion.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples values from before the clock edge.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pvci_rdata  <= '0;
      pvci_rerror <= 1'b0;
`ifdef PVCI2APB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pvci_valid) begin
            paddr       <= APB_BASE | (32'(pvci_addr) << ADDR_SHIFT);
            pwrite      <= ~pvci_rd;
            pwdata      <= {24'b0, pvci_wd};
            pvci_rerror <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
`ifdef PVCI2APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            // Only the low byte reaches the initiator; slave errors still
            // deliver the read data.
            if (!pwrite) pvci_rdata <= prdata[7:0];
            pvci_rerror <= pslverr;
            state       <= RESP;
          end
`ifdef PVCI2APB_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            if (!pwrite) pvci_rdata <= 8'h00;
            pvci_rerror <= 1'b1;
            wait_cnt    <= wait_cnt + 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
